// File: rtl/sys_bridge.sv
// sys_bridge -- memory-stage system bridge between the CPU data port and its slaves.
//
// Purpose:
//   Decodes each M-stage load/store against four windows (data memory, Timer0,
//   Timer1, interrupt generator), steers write strobes and read data, reports
//   illegal accesses as address exceptions, and builds the CPU hardware-interrupt
//   vector from the timer levels and a latched interrupt-generator request.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   m_addr/m_wdata/m_byteen    CPU M-stage address, lane-shifted store data, byte enables
//   m_load/m_wordop/m_kill     load flag, word-sized flag, flush flag
//   m_rdata                    combinational read data back to the CPU
//   m_adel/m_ades              load / store address error
//   dm_addr/dm_wdata/dm_byteen data-memory request; dm_rdata is its read data
//   tc_addr/tc_wdata           shared timer word select and write data
//   tc0_we/tc1_we              per-timer write strobes; tc0_rdata/tc1_rdata read data
//   tc0_irq/tc1_irq            timer interrupt levels
//   interrupt                  interrupt-generator request level
//   m_int_addr/m_int_byteen    interrupt-generator acknowledge bus
//   hw_int                     {3'b0, ig_pend, tc1_q, tc0_q} to CP0

module sys_bridge #(
  parameter logic [31:0] DM_TOP   = 32'h0000_2FFF,
  parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
  parameter logic [31:0] IG_BASE  = 32'h0000_7F20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_byteen,
  input  logic        m_load,
  input  logic        m_wordop,
  input  logic        m_kill,
  output logic [31:0] m_rdata,
  output logic        m_adel,
  output logic        m_ades,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_byteen,
  input  logic [31:0] dm_rdata,
  output logic [1:0]  tc_addr,
  output logic [31:0] tc_wdata,
  output logic        tc0_we,
  output logic        tc1_we,
  input  logic [31:0] tc0_rdata,
  input  logic [31:0] tc1_rdata,
  input  logic        tc0_irq,
  input  logic        tc1_irq,
  input  logic        interrupt,
  output logic [31:0] m_int_addr,
  output logic [3:0]  m_int_byteen,
  output logic [5:0]  hw_int
);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic hit_dm;
  logic hit_tc0;
  logic hit_tc1;
  logic hit_tc;
  logic hit_ig;
  logic hit_any;

  assign hit_dm  = (m_addr <= DM_TOP);
  assign hit_tc0 = (m_addr >= TC0_BASE) && (m_addr <= (TC0_BASE + 32'd11));
  assign hit_tc1 = (m_addr >= TC1_BASE) && (m_addr <= (TC1_BASE + 32'd11));
  assign hit_ig  = (m_addr >= IG_BASE)  && (m_addr <= (IG_BASE + 32'd3));
  assign hit_tc  = hit_tc0 | hit_tc1;
  assign hit_any = hit_dm | hit_tc | hit_ig;

  // ---------------------------------------------------------------------------
  // Exception detection
  // ---------------------------------------------------------------------------
  logic is_store;
  logic tc_sub_word;  // timers only accept word-sized accesses
  logic tc_count_wr;  // the count register (word 2) is read-only
  logic write_block;

  assign is_store    = |m_byteen;
  assign tc_sub_word = hit_tc & ~m_wordop;
  assign tc_count_wr = hit_tc & (m_addr[3:2] == 2'b10);

  assign m_ades = is_store & ~m_kill & (~hit_any | tc_sub_word | tc_count_wr);
  assign m_adel = m_load   & ~m_kill & (~hit_any | tc_sub_word);

  // A flushed or faulting store must not reach any slave. Reset deliberately
  // does not gate writes: every slave handles its own reset.
  assign write_block = m_kill | m_ades;

  // ---------------------------------------------------------------------------
  // Slave request steering
  // ---------------------------------------------------------------------------
  assign dm_addr      = m_addr;
  assign dm_wdata     = m_wdata;
  assign dm_byteen    = (hit_dm & ~write_block) ? m_byteen : 4'h0;

  assign tc_addr      = m_addr[3:2];
  assign tc_wdata     = m_wdata;
  assign tc0_we       = is_store & hit_tc0 & ~write_block;
  assign tc1_we       = is_store & hit_tc1 & ~write_block;

  assign m_int_addr   = m_addr;
  assign m_int_byteen = (hit_ig & ~write_block) ? m_byteen : 4'h0;

  // Read mux. Interrupt-generator loads are legal but return zero, as do
  // unmapped addresses (those also raise m_adel).
  always_comb begin
    m_rdata = 32'h0;
    if (hit_dm) begin
      m_rdata = dm_rdata;
    end else if (hit_tc0) begin
      m_rdata = tc0_rdata;
    end else if (hit_tc1) begin
      m_rdata = tc1_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt state
  // ---------------------------------------------------------------------------
  logic tc0_q;
  logic tc1_q;
  logic interrupt_q;
  logic ig_pend;
  logic ig_pend_next;
  // ig_block remembers that the request level was already high while in reset,
  // so a level that simply persists across reset is not taken as a new edge.
  // It clears the first time the level is seen low.
  logic ig_block;
  logic ig_rise;
  logic ig_ack;

  assign ig_rise = interrupt & ~interrupt_q & ~ig_block;
  assign ig_ack  = |m_int_byteen;

  // A new edge in the same cycle as an acknowledge keeps the request pending.
  always_comb begin
    ig_pend_next = ig_pend;
    if (ig_rise) begin
      ig_pend_next = 1'b1;
    end else if (ig_ack) begin
      ig_pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tc0_q       <= 1'b0;
      tc1_q       <= 1'b0;
      interrupt_q <= 1'b0;
      ig_pend     <= 1'b0;
      ig_block    <= interrupt;
    end else begin
      tc0_q       <= tc0_irq;
      tc1_q       <= tc1_irq;
      interrupt_q <= interrupt;
      ig_pend     <= ig_pend_next;
      ig_block    <= ig_block & interrupt;
    end
  end

  assign hw_int = {3'b000, ig_pend, tc1_q, tc0_q};

endmodule
